// File: rtl/pn_pkg.sv
// Shared PN definitions for the PRBS generator/checker pair.
// Pure declarations: no latency, no flow control.
package pn_pkg;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        VERIFY  = 2'd1,
        LOCKED  = 2'd2
    } pn_chk_state_t;

    localparam int unsigned          PN7_WIDTH    = 7;
    localparam logic [PN7_WIDTH-1:0] PN7_TAPS     = 7'h60;
    localparam int unsigned          PN_MAX_WIDTH = 32;

    // Fibonacci feedback: XOR of the tapped register bits.
    function automatic logic pn_next_bit(input logic [PN_MAX_WIDTH-1:0] state,
                                         input logic [PN_MAX_WIDTH-1:0] taps);
        return ^(state & taps);
    endfunction

endpackage

// File: rtl/pn_err_window.sv
// Per-window bit/error counters for lock-loss detection; loss is combinational from the current bit.
// Counters advance only on bit_tick; clr holds them at zero while not locked.
module pn_err_window #(
    parameter int unsigned WINDOW_LEN  = 64,
    parameter int unsigned LOSS_THRESH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic bit_tick,
    input  logic err_tick,
    output logic loss
);

    localparam int unsigned WB_W = $clog2(WINDOW_LEN + 1);

    logic [WB_W-1:0] win_bits_q, win_bits_d;
    logic [WB_W-1:0] win_errs_q, win_errs_d;
    logic            win_end;

    assign loss    = bit_tick && err_tick &&
                     ((win_errs_q + WB_W'(1)) == WB_W'(LOSS_THRESH));
    assign win_end = (win_bits_q + WB_W'(1)) == WB_W'(WINDOW_LEN);

    always_comb begin
        win_bits_d = win_bits_q;
        win_errs_d = win_errs_q;
        // Loss outranks the window boundary when both land on the same bit.
        if (clr || loss) begin
            win_bits_d = '0;
            win_errs_d = '0;
        end else if (bit_tick) begin
            if (win_end) begin
                win_bits_d = '0;
                win_errs_d = '0;
            end else begin
                win_bits_d = win_bits_q + WB_W'(1);
                win_errs_d = win_errs_q + WB_W'(err_tick);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            win_bits_q <= '0;
            win_errs_q <= '0;
        end else begin
            win_bits_q <= win_bits_d;
            win_errs_q <= win_errs_d;
        end
    end

endmodule

// File: rtl/pn_sequence_checker.sv
// Self-synchronising PN checker: acquire, verify, lock, then count bit errors against a free-running LFSR.
// Outputs registered one cycle after the causing valid bit; pn_valid=0 stalls everything except bit_err/clear.
module pn_sequence_checker
    import pn_pkg::*;
#(
    parameter int unsigned         PN_WIDTH    = PN7_WIDTH,
    parameter logic [PN_WIDTH-1:0] PN_TAPS     = PN7_TAPS,
    parameter int unsigned         LOCK_COUNT  = 16,
    parameter int unsigned         WINDOW_LEN  = 64,
    parameter int unsigned         LOSS_THRESH = 8,
    parameter int unsigned         CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pn_in,
    input  logic                 pn_valid,
    input  logic                 clear_counts,
    output logic                 locked,
    output logic                 bit_err,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic [CNT_WIDTH-1:0] bit_count
);

    localparam int unsigned FILL_W  = $clog2(PN_WIDTH + 1);
    localparam int unsigned MATCH_W = 8;

    pn_chk_state_t        state_q, state_d;
    logic [PN_WIDTH-1:0]  s_q, s_d;
    logic [FILL_W-1:0]    fill_q, fill_d;
    logic [MATCH_W-1:0]   match_q, match_d;
    logic                 locked_q, locked_d;
    logic                 bit_err_q, bit_err_d;
    logic [CNT_WIDTH-1:0] err_count_q, err_count_d;
    logic [CNT_WIDTH-1:0] bit_count_q, bit_count_d;

    logic                pred;
    logic                mismatch;
    logic [PN_WIDTH-1:0] s_shift_in;
    logic                bit_tick;
    logic                err_tick;
    logic                win_clr;
    logic                loss;

    assign pred       = pn_next_bit(PN_MAX_WIDTH'(s_q), PN_MAX_WIDTH'(PN_TAPS));
    assign mismatch   = pn_in ^ pred;
    assign s_shift_in = {s_q[PN_WIDTH-2:0], pn_in};
    assign bit_tick   = pn_valid && (state_q == LOCKED);
    assign err_tick   = bit_tick && mismatch;
    assign win_clr    = (state_q != LOCKED);

    pn_err_window #(
        .WINDOW_LEN  (WINDOW_LEN),
        .LOSS_THRESH (LOSS_THRESH)
    ) u_err_window (
        .clk      (clk),
        .reset    (reset),
        .clr      (win_clr),
        .bit_tick (bit_tick),
        .err_tick (err_tick),
        .loss     (loss)
    );

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        fill_d      = fill_q;
        match_d     = match_q;
        locked_d    = locked_q;
        bit_err_d   = 1'b0;
        err_count_d = err_count_q;
        bit_count_d = bit_count_q;

        if (pn_valid) begin
            unique case (state_q)
                ACQUIRE: begin
                    s_d = s_shift_in;
                    if ((fill_q + FILL_W'(1)) == FILL_W'(PN_WIDTH)) begin
                        fill_d = '0;
                        // An all-zero register would predict zeros forever; keep filling.
                        if (s_shift_in != '0) begin
                            state_d = VERIFY;
                            match_d = '0;
                        end
                    end else begin
                        fill_d = fill_q + FILL_W'(1);
                    end
                end
                VERIFY: begin
                    s_d = s_shift_in;
                    if (mismatch || (s_q == '0)) begin
                        state_d = ACQUIRE;
                        fill_d  = '0;
                        match_d = '0;
                    end else if ((match_q + MATCH_W'(1)) == MATCH_W'(LOCK_COUNT)) begin
                        state_d  = LOCKED;
                        locked_d = 1'b1;
                        match_d  = '0;
                    end else begin
                        match_d = match_q + MATCH_W'(1);
                    end
                end
                LOCKED: begin
                    // Free-run on the prediction so a corrupted bit never enters the register.
                    s_d         = {s_q[PN_WIDTH-2:0], pred};
                    bit_count_d = (bit_count_q == '1) ? bit_count_q
                                                      : bit_count_q + CNT_WIDTH'(1);
                    if (mismatch) begin
                        bit_err_d   = 1'b1;
                        err_count_d = (err_count_q == '1) ? err_count_q
                                                          : err_count_q + CNT_WIDTH'(1);
                    end
                    if (loss) begin
                        state_d  = ACQUIRE;
                        locked_d = 1'b0;
                        fill_d   = '0;
                    end
                end
                default: begin
                    state_d  = ACQUIRE;
                    locked_d = 1'b0;
                    fill_d   = '0;
                    match_d  = '0;
                end
            endcase
        end

        if (clear_counts) begin
            err_count_d = '0;
            bit_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ACQUIRE;
            s_q         <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            locked_q    <= 1'b0;
            bit_err_q   <= 1'b0;
            err_count_q <= '0;
            bit_count_q <= '0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            locked_q    <= locked_d;
            bit_err_q   <= bit_err_d;
            err_count_q <= err_count_d;
            bit_count_q <= bit_count_d;
        end
    end

    assign locked    = locked_q;
    assign bit_err   = bit_err_q;
    assign err_count = err_count_q;
    assign bit_count = bit_count_q;

endmodule

// File: tb/tb_pn_sequence_checker.sv
// Bench for pn_sequence_checker: PRBS-7 source with injected errors, compared every cycle
// against a history-queue reference model. Narrow counters so saturation is reached.
module tb_pn_sequence_checker;

    localparam int CNT_W   = 8;
    localparam int CMAX    = (1 << CNT_W) - 1;
    localparam int LOCK_N  = 16;
    localparam int WIN_N   = 64;
    localparam int THRESH  = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             pn_in;
    logic             pn_valid;
    logic             clear_counts;
    logic             locked;
    logic             bit_err;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] bit_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pn_sequence_checker #(
        .CNT_WIDTH (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pn_in        (pn_in),
        .pn_valid     (pn_valid),
        .clear_counts (clear_counts),
        .locked       (locked),
        .bit_err      (bit_err),
        .err_count    (err_count),
        .bit_count    (bit_count)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // PRBS-7 source: b[n] = b[n-7] ^ b[n-6]
    bit gen_hist[$];

    function automatic bit gen_next();
        bit b;
        b = gen_hist[0] ^ gen_hist[1];
        gen_hist.push_back(b);
        void'(gen_hist.pop_front());
        return b;
    endfunction

    // Reference model: last seven bits held by the checker plus mode/counters.
    bit m_hist[$];
    int m_mode;      // 0 acquire, 1 verify, 2 locked
    int m_fill, m_match, m_wb, m_we, m_ec, m_bc;
    bit m_biterr;

    function automatic bit m_hist_zero();
        foreach (m_hist[i]) if (m_hist[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void m_push(input bit b);
        m_hist.push_back(b);
        void'(m_hist.pop_front());
    endfunction

    function automatic void model_reset();
        m_hist.delete();
        for (int i = 0; i < 7; i++) m_hist.push_back(1'b0);
        m_mode = 0; m_fill = 0; m_match = 0; m_wb = 0; m_we = 0;
        m_ec = 0; m_bc = 0; m_biterr = 1'b0;
    endfunction

    function automatic void model_step(input bit v, input bit b, input bit clr);
        bit p, was_zero;
        m_biterr = 1'b0;
        if (v) begin
            p        = m_hist[0] ^ m_hist[1];
            was_zero = m_hist_zero();
            case (m_mode)
                0: begin
                    m_push(b);
                    m_fill++;
                    if (m_fill == 7) begin
                        m_fill = 0;
                        if (!m_hist_zero()) begin m_mode = 1; m_match = 0; end
                    end
                end
                1: begin
                    m_push(b);
                    if (b != p || was_zero) begin
                        m_mode = 0; m_fill = 0; m_match = 0;
                    end else begin
                        m_match++;
                        if (m_match == LOCK_N) begin
                            m_mode = 2; m_match = 0; m_wb = 0; m_we = 0;
                        end
                    end
                end
                default: begin
                    m_push(p);
                    if (m_bc < CMAX) m_bc++;
                    m_wb++;
                    if (b != p) begin
                        m_biterr = 1'b1;
                        if (m_ec < CMAX) m_ec++;
                        m_we++;
                    end
                    if (m_we == THRESH) begin
                        m_mode = 0; m_fill = 0;
                    end else if (m_wb == WIN_N) begin
                        m_wb = 0; m_we = 0;
                    end
                end
            endcase
        end
        if (clr) begin m_ec = 0; m_bc = 0; end
    endfunction

    task automatic compare_all();
        check_val("locked", locked, (m_mode == 2));
        check_val("bit_err", bit_err, m_biterr);
        check_val("err_count", err_count, m_ec);
        check_val("bit_count", bit_count, m_bc);
    endtask

    task automatic cycle(input bit v, input bit b, input bit clr);
        pn_valid     = v;
        pn_in        = b;
        clear_counts = clr;
        @(posedge clk);
        #1;
        model_step(v, b, clr);
        compare_all();
    endtask

    // Valid bits come from the PRBS source (optionally inverted); invalid bits are junk.
    task automatic send(input bit v, input bit err, input bit clr);
        bit b;
        if (v) b = gen_next() ^ err;
        else   b = 1'($urandom_range(0, 1));
        cycle(v, b, clr);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        pn_valid     = 1'b1;
        pn_in        = 1'($urandom_range(0, 1));
        clear_counts = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        check_val("rst_locked", locked, 0);
        check_val("rst_bit_err", bit_err, 0);
        check_val("rst_err_count", err_count, 0);
        check_val("rst_bit_count", bit_count, 0);
    endtask

    task automatic align_window();
        for (int i = 0; i < WIN_N; i++) begin
            if (m_wb == 0) break;
            send(1'b1, 1'b0, 1'b0);
        end
        check_val("window_aligned", m_wb, 0);
    endtask

    initial begin
        int start, rate;
        bit hit;

        reset = 1'b1; pn_valid = 1'b0; pn_in = 1'b0; clear_counts = 1'b0;
        gen_hist.delete();
        for (int i = 0; i < 7; i++) gen_hist.push_back(1'($urandom_range(0, 1)));
        gen_hist[0] = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        // Clean stream: lock after 7 fill + 16 verify bits.
        for (int i = 0; i < 22; i++) send(1'b1, 1'b0, 1'b0);
        check_val("lock_pre_23", locked, 0);
        send(1'b1, 1'b0, 1'b0);
        check_val("lock_at_23", locked, 1);
        for (int i = 0; i < 200; i++) send(1'b1, 1'b0, 1'b0);
        check_val("clean_bit_count", bit_count, 200);
        check_val("clean_err_count", err_count, 0);

        // Single injected error.
        send(1'b1, 1'b1, 1'b0);
        check_val("single_bit_err", bit_err, 1);
        check_val("single_err_count", err_count, 1);
        check_val("single_locked", locked, 1);
        for (int i = 0; i < 20; i++) send(1'b1, 1'b0, 1'b0);
        check_val("single_no_propagate", err_count, 1);

        // Seven errors per window over three windows: lock held.
        align_window();
        for (int w = 0; w < 3; w++) begin
            start = $urandom_range(0, 8);
            for (int i = 0; i < WIN_N; i++) begin
                hit = (i >= start) && (((i - start) % 9) == 0) && (i - start < 63);
                send(1'b1, hit, 1'b0);
            end
        end
        check_val("seven_per_window_locked", locked, 1);
        check_val("seven_per_window_errs", err_count, 22);

        // Eight errors in one window: lock lost on the eighth.
        align_window();
        for (int k = 0; k < 8; k++) begin
            send(1'b1, 1'b1, 1'b0);
            if (k < 7) begin
                send(1'b1, 1'b0, 1'b0);
                send(1'b1, 1'b0, 1'b0);
            end
        end
        check_val("loss_on_8th", locked, 0);
        for (int i = 0; i < 22; i++) send(1'b1, 1'b0, 1'b0);
        check_val("relock_pre_23", locked, 0);
        send(1'b1, 1'b0, 1'b0);
        check_val("relock_at_23", locked, 1);

        // Clear in the same cycle as an error: clear wins, pulse still fires.
        send(1'b1, 1'b1, 1'b1);
        check_val("clr_err_count", err_count, 0);
        check_val("clr_bit_count", bit_count, 0);
        check_val("clr_bit_err", bit_err, 1);

        // Reset while locked.
        do_reset();

        // pn_valid toggling every cycle.
        for (int i = 0; i < 22; i++) begin
            send(1'b1, 1'b0, 1'b0);
            send(1'b0, 1'b0, 1'b0);
        end
        check_val("toggle_pre_lock", locked, 0);
        send(1'b1, 1'b0, 1'b0);
        check_val("toggle_lock", locked, 1);
        send(1'b0, 1'b0, 1'b0);
        check_val("toggle_idle_count", bit_count, 0);

        // All-zero stream never locks.
        do_reset();
        for (int i = 0; i < 150; i++) cycle(1'b1, 1'b0, 1'b0);
        check_val("zero_stream_locked", locked, 0);

        // Randomised traffic at several error rates.
        do_reset();
        for (int ph = 0; ph < 4; ph++) begin
            rate = (ph == 0) ? 300 : (ph == 1) ? 30 : (ph == 2) ? 6 : 60;
            for (int i = 0; i < 600; i++) begin
                send(($urandom_range(0, 3) != 0),
                     ($urandom_range(0, rate - 1) == 0),
                     ($urandom_range(0, 199) == 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pn_sequence_checker.md
Name: pn_sequence_checker

Overview:
- Receive-side counterpart of pn_sequence_generator: takes a serial PN bit stream (loop-back from the generator or from the DEM dither path).
- Self-synchronises a local LFSR to the stream, declares lock, then counts bit errors against the locally predicted sequence.
- Used in DEM-DAC bring-up and BIST to prove the dither/scrambling PN source is intact end to end.

Parameters:
- PN_WIDTH, 7, LFSR length in bits.
- PN_TAPS, 7'h60, feedback tap mask. Default is x^7+x^6+1, Fibonacci form, identical to the generator's polynomial.
- LOCK_COUNT, 16, consecutive correct predictions in VERIFY required to declare lock (1..255).
- WINDOW_LEN, 64, bits per lock-loss observation window (2..65535).
- LOSS_THRESH, 8, errors within one window that force loss of lock (1..WINDOW_LEN).
- CNT_WIDTH, 16, width of the saturating error and bit counters.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- pn_in  in  1  received PN bit.
- pn_valid  in  1  pn_in is sampled only in cycles where this is high.
- clear_counts  in  1  single-cycle pulse that zeroes err_count and bit_count.
- locked  out  1  high while in the LOCKED state.
- bit_err  out  1  one-cycle pulse marking a mismatched bit while LOCKED.
- err_count  out  CNT_WIDTH  saturating count of errors while LOCKED.
- bit_count  out  CNT_WIDTH  saturating count of bits checked while LOCKED.

Behaviour:
- One clock; reset is synchronous and active-high. On reset: state=ACQUIRE, LFSR register s=0, fill/match/window counters=0, locked=0, bit_err=0, err_count=0, bit_count=0.
- Reset asserted mid-operation behaves identically to power-on reset on the next edge.
- Prediction: pred = ^(s & PN_TAPS).
- All outputs are registered. bit_err, counter updates and locked changes appear one cycle after the pn_valid cycle that causes them.
- Cycles with pn_valid=0 change nothing. The exceptions are bit_err, which returns to 0, and clear_counts, which still acts.
- ACQUIRE:
  - On each valid bit, s <= {s[PN_WIDTH-2:0], pn_in} and fill++.
  - When fill reaches PN_WIDTH: go to VERIFY with match=0, unless the new s==0, in which case stay in ACQUIRE with fill=0 (all-zero lock-up guard).
- VERIFY:
  - Each valid bit still shifts pn_in into s (self-sync).
  - pn_in==pred: match++. When match reaches LOCK_COUNT, go to LOCKED; locked=1 from the following cycle; window counters=0.
  - pn_in!=pred, or s==0: return to ACQUIRE with fill=0, match=0.
- LOCKED:
  - s free-runs on the prediction, s <= {s[PN_WIDTH-2:0], pred], so one received error does not propagate.
  - Each valid bit: bit_count++ and win_bits++. If pn_in!=pred: bit_err=1, err_count++, win_errs++.
  - If win_errs+error reaches LOSS_THRESH: go to ACQUIRE, locked=0 next cycle, fill=0. err_count and bit_count are retained.
  - Otherwise, when win_bits reaches WINDOW_LEN: win_bits=0, win_errs=0.
  - If the threshold hit and the window end fall on the same bit, loss of lock wins.
- Counters saturate at 2^CNT_WIDTH-1 and never wrap.
- clear_counts has priority over a same-cycle increment: the result is 0 and that bit's increment is dropped. bit_err still pulses.
- Lock latency from reset with a clean stream: PN_WIDTH+LOCK_COUNT valid bits, plus 1 cycle to the locked output.

Decomposition:
- Package pn_pkg holds:
  - enum pn_chk_state_t {ACQUIRE, VERIFY, LOCKED};
  - constants PN7_WIDTH=7 and PN7_TAPS=7'h60, shared with pn_sequence_generator;
  - function pn_next_bit(state, taps) returning the XOR-reduced feedback.
- Sub-module pn_err_window: win_bits/win_errs counters with inputs bit_tick, err_tick, clr, and output loss pulse. The FSM, LFSR and saturating counters stay in the top module.

Test Plan:
- Clean PRBS-7 stream from pn_sequence_generator, pn_valid=1 every cycle -> locked rises exactly 24 cycles after the first valid bit (7+16+1); err_count stays 0; after 200 more bits, bit_count=200.
- Locked, one bit inverted -> single bit_err pulse one cycle later, err_count=1, locked stays 1, and the following bits are error-free.
- Locked, 8 inverted bits within one 64-bit window -> locked falls one cycle after the 8th; relock after a further 23 clean bits. 7 errors per window, repeated over several windows -> lock held.
- pn_valid toggled 1/0 every cycle with a clean stream -> locks after 23 valid bits (~46 cycles); no state or counter changes on invalid cycles.
- All-zero input stream -> never leaves ACQUIRE/VERIFY, and locked stays 0.
- clear_counts pulsed in the same cycle as an injected error -> err_count=0, bit_err=1. Reset pulsed while locked -> all outputs 0 next cycle.
